// File: rtl/switch_pkg.sv
// Shared switch definitions: port count, port index type, per-output lock
// states and header destination decode.
package switch_pkg;

  localparam int NPORTS = 3;

  typedef logic [1:0] port_idx_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  // Header bits [1:0]: 01 -> port 0, 11 -> port 2, 00 and 10 -> port 1.
  function automatic port_idx_t dest_decode(input logic [1:0] hdr);
    case (hdr)
      2'b01:   return port_idx_t'(0);
      2'b11:   return port_idx_t'(2);
      default: return port_idx_t'(1);
    endcase
  endfunction

  function automatic port_idx_t port_inc(input port_idx_t p);
    return (p == port_idx_t'(NPORTS - 1)) ? port_idx_t'(0) : port_idx_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Input-FIFO head / output-RAM write bundle of the output port arbiter.
// ARB_STATS_EN adds the per-output grant counters.
interface output_port_arbiter_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  import switch_pkg::*;

  logic [NPORTS-1:0][DW-1:0]    in_data;
  logic [NPORTS-1:0]            in_valid;
  logic [NPORTS-1:0]            in_last;
  logic [NPORTS-1:0]            in_pop;
  logic [NPORTS-1:0]            out_full;
  logic [NPORTS-1:0]            out_wr;
  logic [NPORTS-1:0][DW-1:0]    out_data;
`ifdef ARB_STATS_EN
  logic [NPORTS-1:0][CNT_W-1:0] grant_cnt;
`endif

  modport master (
    input  in_data, in_valid, in_last, out_full,
    output in_pop, out_wr, out_data
`ifdef ARB_STATS_EN
    , output grant_cnt
`endif
  );

  modport slave (
    output in_data, in_valid, in_last, out_full,
    input  in_pop, out_wr, out_data
`ifdef ARB_STATS_EN
    , input grant_cnt
`endif
  );

endinterface

// File: rtl/rr_port_lock.sv
// Per-output round-robin grant and packet lock. ARB_STATS_EN adds a
// wrapping count of IDLE->LOCKED transitions.
module rr_port_lock
  import switch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NPORTS-1:0] req,
  input  logic              pop,
  input  logic              pop_last,
  output logic              locked,
  output port_idx_t         owner
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt
`endif
);

  lock_state_t state_reg, state_next;
  port_idx_t   ptr_reg, ptr_next;
  port_idx_t   owner_reg, owner_next;
  logic        grant;
  port_idx_t   cand [NPORTS];

  // Search order ptr+1, ptr+2, ptr: the last owner gets lowest priority.
  assign cand[0] = port_inc(ptr_reg);
  assign cand[1] = port_inc(cand[0]);
  assign cand[2] = ptr_reg;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    grant      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          for (int k = 0; k < NPORTS; k++) begin
            if (!grant && req[cand[k]]) begin
              grant      = 1'b1;
              owner_next = cand[k];
              state_next = ST_LOCKED;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (pop && pop_last) begin
          state_next = ST_IDLE;
          ptr_next   = owner_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= port_idx_t'(2);
      owner_reg <= port_idx_t'(0);
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  assign locked = (state_reg == ST_LOCKED);
  assign owner  = owner_reg;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (grant) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign grant_cnt = cnt_reg;
`endif

endmodule

// File: rtl/output_port_arbiter.sv
// Three-output packet arbiter: per-output round-robin locks, cross-output input
// exclusion, registered output RAM writes. Define ARB_STATS_EN for grant counters.
module output_port_arbiter
  import switch_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output_port_arbiter_if.master bus
);

  logic [NPORTS-1:0] locked;
  logic [NPORTS-1:0] pop_o;
  logic [NPORTS-1:0] pop_last;
  port_idx_t         owner    [NPORTS];
  port_idx_t         in_dest  [NPORTS];
  logic [NPORTS-1:0] own_mat  [NPORTS];
  logic [NPORTS-1:0] pop_mat  [NPORTS];
  logic [NPORTS-1:0] in_locked;
  logic [NPORTS-1:0] in_pop_c;

  genvar gi, gj;

  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_in
      assign in_dest[gi] = dest_decode(bus.in_data[gi][1:0]);
    end
  endgenerate

  // An input already locked to some output is streaming payload, not a header.
  always_comb begin
    in_locked = '0;
    in_pop_c  = '0;
    for (int o = 0; o < NPORTS; o++) begin
      in_locked = in_locked | own_mat[o];
      in_pop_c  = in_pop_c | pop_mat[o];
    end
  end

  assign bus.in_pop = rst_n ? in_pop_c : '0;

  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_out
      logic [NPORTS-1:0] req;
      logic              wr_reg;
      logic [DW-1:0]     data_reg;

      for (gj = 0; gj < NPORTS; gj++) begin : g_req
        assign req[gj] = bus.in_valid[gj] && !in_locked[gj] &&
                         (in_dest[gj] == port_idx_t'(gi));
      end

      assign own_mat[gi]  = locked[gi] ? (NPORTS'(1) << owner[gi]) : '0;
      assign pop_mat[gi]  = own_mat[gi] & bus.in_valid & {NPORTS{!bus.out_full[gi]}};
      assign pop_o[gi]    = |pop_mat[gi];
      assign pop_last[gi] = |(pop_mat[gi] & bus.in_last);

      rr_port_lock #(
        .CNT_W (CNT_W)
      ) u_lock (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .pop       (pop_o[gi]),
        .pop_last  (pop_last[gi]),
        .locked    (locked[gi]),
        .owner     (owner[gi])
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (bus.grant_cnt[gi])
`endif
      );

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_reg   <= 1'b0;
          data_reg <= '0;
        end else begin
          wr_reg <= pop_o[gi];
          if (pop_o[gi]) begin
            data_reg <= bus.in_data[owner[gi]];
          end
        end
      end

      assign bus.out_wr[gi]   = wr_reg;
      assign bus.out_data[gi] = data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus randomized traffic
// against a packet-level reference model of the arbitration rules.
module tb_output_port_arbiter;

  localparam int DW    = 32;
  localparam int CNT_W = 16;
  localparam int NP    = 3;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;

  output_port_arbiter_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  output_port_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  word_t         src_q  [NP][$];
  logic [DW-1:0] wr_log [NP][$];
  int            pop_log[$];

  int n_cmp = 0;
  int n_err = 0;
  int bubble_pct = 0;
  int full_pct   = 0;
  int dis_pct    = 0;
  logic [NP-1:0] full_force = '0;
  int words_pushed  = 0;
  int words_written = 0;
  logic [NP-1:0] obs_pop;

  // Reference model: owner per output (-1 = free), round-robin pointer,
  // expected output data register and grant count.
  int               m_own  [NP];
  int               m_ptr  [NP];
  logic [DW-1:0]    m_data [NP];
  logic [CNT_W-1:0] m_cnt  [NP];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dest_of(input logic [1:0] h);
    case (h)
      2'b01:   return 0;
      2'b11:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit owned(input int c);
    for (int o = 0; o < NP; o++) if (m_own[o] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NP; i++) p += src_q[i].size();
    for (int o = 0; o < NP; o++) if (m_own[o] >= 0) p++;
    return p;
  endfunction

  task automatic push_pkt(input int src, input int dest, input int len);
    word_t w;
    logic [1:0] code;
    code = (dest == 0) ? 2'b01 : (dest == 2) ? 2'b11 : ($urandom_range(1) != 0 ? 2'b10 : 2'b00);
    for (int k = 0; k < len; k++) begin
      w.data = $urandom;
      if (k == 0) w.data[1:0] = code;
      w.last = (k == len - 1);
      src_q[src].push_back(w);
      words_pushed++;
    end
  endtask

  task automatic run_cycle();
    logic [NP-1:0]    vld, exp_pop, rel, nxt_wr;
    logic [NP*DW-1:0] exp_data;
    int               gnt [NP];
    int               s, c;
    for (int i = 0; i < NP; i++) begin
      vld[i] = (src_q[i].size() > 0) && ($urandom_range(99) >= bubble_pct);
      bus.in_valid[i] = vld[i];
      if (vld[i]) begin
        bus.in_data[i] = src_q[i][0].data;
        bus.in_last[i] = src_q[i][0].last;
      end else begin
        bus.in_data[i] = $urandom;
        bus.in_last[i] = 1'($urandom);
      end
      bus.out_full[i] = full_force[i] || ($urandom_range(99) < full_pct);
    end
    enable = ($urandom_range(99) >= dis_pct);

    @(negedge clk);
    exp_pop = '0;
    rel     = '0;
    nxt_wr  = '0;
    for (int o = 0; o < NP; o++) gnt[o] = -1;
    if (!rst_n) begin
      for (int o = 0; o < NP; o++) begin
        m_own[o]  = -1;
        m_ptr[o]  = 2;
        m_data[o] = '0;
        m_cnt[o]  = '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (m_own[o] >= 0) begin
          s = m_own[o];
          if (vld[s] && !bus.out_full[o]) begin
            exp_pop[s] = 1'b1;
            nxt_wr[o]  = 1'b1;
            m_data[o]  = src_q[s][0].data;
            rel[o]     = src_q[s][0].last;
          end
        end else if (enable) begin
          for (int k = 1; k <= NP; k++) begin
            c = (m_ptr[o] + k) % NP;
            if (gnt[o] < 0 && vld[c] && dest_of(src_q[c][0].data[1:0]) == o && !owned(c))
              gnt[o] = c;
          end
        end
      end
    end
    obs_pop = bus.in_pop;
    chk("in_pop", obs_pop, exp_pop);
    for (int i = 0; i < NP; i++) begin
      if (obs_pop[i]) pop_log.push_back(i);
      if (exp_pop[i]) void'(src_q[i].pop_front());
    end
    for (int o = 0; o < NP; o++) begin
      if (rel[o]) begin
        m_ptr[o] = m_own[o];
        m_own[o] = -1;
      end
      if (gnt[o] >= 0) begin
        m_own[o] = gnt[o];
        m_cnt[o] = m_cnt[o] + 1'b1;
      end
    end

    @(posedge clk);
    #1;
    for (int o = 0; o < NP; o++) if (bus.out_wr[o]) wr_log[o].push_back(bus.out_data[o]);
    words_written += $countones(bus.out_wr);
    chk("out_wr", bus.out_wr, nxt_wr);
    exp_data = {m_data[2], m_data[1], m_data[0]};
    chk("out_data", bus.out_data, exp_data);
`ifdef ARB_STATS_EN
    chk("grant_cnt", bus.grant_cnt, {m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (pending() != 0 && n < max_cycles) begin
      run_cycle();
      n++;
    end
    run_cycle();
    chk({tag, "_drained"}, pending(), 0);
  endtask

  initial begin
    word_t         w;
    int            exp030 [6] = '{0, 1, 2, 0, 1, 2};
    int            exp032 [4] = '{0, 0, 0, 2};
    logic [DW-1:0] exp_words [4];
    int            flushed;

    for (int i = 0; i < NP; i++) begin
      bus.in_valid[i] = 1'b0;
      bus.in_last[i]  = 1'b0;
      bus.in_data[i]  = '0;
      bus.out_full[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_out_wr", bus.out_wr, 0);
    chk("rst_out_data", bus.out_data, 0);

    // Single-word header 0x1 from input 1 to output 0.
    w.last = 1'b1;
    w.data = 32'h0000_0001;
    src_q[1].push_back(w);
    words_pushed++;
    run_cycle();
    chk("t029_grant_no_pop", obs_pop, 0);
    run_cycle();
    chk("t029_pop", obs_pop, 3'b010);
    chk("t029_wr", bus.out_wr, 3'b001);
    chk("t029_data", bus.out_data[0], 32'h0000_0001);
    run_cycle();
    chk("t029_wr_after", bus.out_wr, 0);

    // Three inputs, single-word packets all to output 2: round-robin order.
    pop_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NP; i++) push_pkt(i, 2, 1);
    drain("t030", 60);
    chk("t030_count", pop_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < pop_log.size()) chk("t030_order", pop_log[k], exp030[k]);

    // 4-word packet with output 1 full for 3 cycles mid-packet.
    for (int o = 0; o < NP; o++) wr_log[o].delete();
    push_pkt(2, 1, 4);
    for (int k = 0; k < 4; k++) exp_words[k] = src_q[2][k].data;
    run_cycle();
    run_cycle();
    run_cycle();
    full_force = 3'b010;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      chk("t031_full_no_pop", obs_pop, 0);
    end
    chk("t031_full_no_wr", bus.out_wr, 0);
    full_force = '0;
    drain("t031", 40);
    chk("t031_count", wr_log[1].size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < wr_log[1].size()) chk("t031_word", wr_log[1][k], exp_words[k]);

    // Locked packet from input 0 holds off a competing input 2.
    do_reset();
    pop_log.delete();
    push_pkt(0, 0, 3);
    push_pkt(2, 0, 1);
    drain("t032", 40);
    chk("t032_count", pop_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < pop_log.size()) chk("t032_order", pop_log[k], exp032[k]);

    // Reset in the middle of a packet, then a fresh packet.
    push_pkt(1, 2, 4);
    run_cycle();
    run_cycle();
    run_cycle();
    rst_n = 1'b0;
    run_cycle();
    chk("t033_rst_no_pop", obs_pop, 0);
    chk("t033_rst_no_wr", bus.out_wr, 0);
    rst_n = 1'b1;
    flushed = 0;
    for (int i = 0; i < NP; i++) begin
      flushed += src_q[i].size();
      src_q[i].delete();
    end
    words_pushed -= flushed;
    for (int o = 0; o < NP; o++) wr_log[o].delete();
    push_pkt(0, 1, 2);
    exp_words[0] = src_q[0][0].data;
    exp_words[1] = src_q[0][1].data;
    drain("t033", 40);
    chk("t033_count", wr_log[1].size(), 2);
    for (int k = 0; k < 2; k++)
      if (k < wr_log[1].size()) chk("t033_word", wr_log[1][k], exp_words[k]);

    // Five packets to output 1 from mixed inputs.
    do_reset();
    for (int k = 0; k < 5; k++) push_pkt(k % NP, 1, 1 + (k % 3));
    drain("t034", 80);
`ifdef ARB_STATS_EN
    chk("t034_grant_cnt", bus.grant_cnt, {16'd0, 16'd5, 16'd0});
`endif

    // Randomized traffic with bubbles, back-pressure and enable gaps.
    bubble_pct = 25;
    full_pct   = 20;
    dis_pct    = 10;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 30) begin
        int src;
        src = int'($urandom_range(NP - 1));
        if (src_q[src].size() < 10)
          push_pkt(src, int'($urandom_range(NP - 1)), int'($urandom_range(4, 1)));
      end
      run_cycle();
    end
    bubble_pct = 0;
    full_pct   = 0;
    dis_pct    = 0;
    drain("rand", 600);
    chk("words_total", words_written, words_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
